sd_cmd_sequencer: RTL and testbench



---
 rtl/sd_cmd_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_sd_cmd_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sd_cmd_sequencer                                           |
// | Description : SPI-mode SD card command engine. Sends power-up dummy      |
// |               clocks, serialises 48-bit command frames and collects R1   |
// |               or R1 + 32-bit responses with an NCR byte timeout.         |
// | Ports       : CLK100MHZ/CPU_RESETN  clock, synchronous active-low reset  |
// |               start/init_req        request pulses (taken when idle)     |
// |               cmd_index/arg/crc     command fields, sampled on accept    |
// |               resp_len              0 = R1, 1 = R1 + 4 bytes             |
// |               busy/done/timeout     status; r1/r_ext response bytes      |
// |               SD_SCK/MOSI/MISO      SPI mode-0 card pins                 |
// | Option      : `define SD_CRC7_EN computes CRC7 in hardware and ignores   |
// |               cmd_crc.                                                   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module sd_cmd_sequencer #(
  parameter int CLK_DIV   = 125,
  parameter int NCR_MAX   = 8,
  parameter int INIT_CLKS = 80
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic        start,
  input  logic        init_req,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  cmd_crc,
  input  logic        resp_len,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [7:0]  r1,
  output logic [31:0] r_ext,
  output logic        SD_SCK,
  output logic        SD_MOSI,
  input  logic        SD_MISO
);

  localparam int c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_BIT_MAX = (INIT_CLKS > 48) ? INIT_CLKS : 48;
  localparam int c_BIT_W   = $clog2(c_BIT_MAX + 1);
  localparam int c_BYTE_W  = (NCR_MAX > 1) ? $clog2(NCR_MAX) : 1;

  localparam logic [c_DIV_W-1:0]  c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_BYTE_W-1:0] c_NCR_LAST = c_BYTE_W'(NCR_MAX - 1);

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_INIT     = 3'd1;
  localparam logic [2:0] c_PRE      = 3'd2;
  localparam logic [2:0] c_SEND     = 3'd3;
  localparam logic [2:0] c_WAIT     = 3'd4;
  localparam logic [2:0] c_READ_EXT = 3'd5;
  localparam logic [2:0] c_POST     = 3'd6;
  localparam logic [2:0] c_DONE     = 3'd7;

  logic [2:0]          r_state;
  logic [2:0]          w_state_nxt;
  logic [c_DIV_W-1:0]  r_div;
  logic                r_sck;
  logic [c_BIT_W-1:0]  r_bit;
  logic [c_BIT_W-1:0]  w_last_idx;
  logic [c_BYTE_W-1:0] r_byte;
  logic [47:0]         r_frame;
  logic [7:0]          r_shift;
  logic                r_resp_len;
  logic                r_timeout;
  logic [7:0]          r_r1;
  logic [31:0]         r_ext_q;
  logic [6:0]          w_crc;
  logic                w_active;
  logic                w_half_end;
  logic                w_rise;
  logic                w_fall;
  logic                w_bit_last;
  logic                w_bit_end;
  logic                w_accept_any;
  logic                w_accept_cmd;

`ifdef SD_CRC7_EN
  // Bit-serial CRC7 (x^7 + x^3 + 1), MSB first, seed 0.
  function automatic logic [6:0] f_crc7(input logic [39:0] msg);
    logic [6:0] crc;
    logic       fb;
    crc = '0;
    for (int i = 39; i >= 0; i--) begin
      fb  = msg[i] ^ crc[6];
      crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return crc;
  endfunction

  logic w_unused_crc;
  assign w_crc        = f_crc7({2'b01, cmd_index, cmd_arg});
  assign w_unused_crc = ^cmd_crc;
`else
  assign w_crc = cmd_crc;
`endif

  // Every state except IDLE/DONE is clocking the card.
  assign w_active     = (r_state != c_IDLE) && (r_state != c_DONE);
  assign w_half_end   = w_active && (r_div == c_DIV_LAST);
  assign w_rise       = w_half_end && !r_sck;
  assign w_fall       = w_half_end && r_sck;
  assign w_bit_last   = (r_bit == w_last_idx);
  // All state moves happen here, at the end of a high half, so SCK lands low.
  assign w_bit_end    = w_fall && w_bit_last;
  assign w_accept_any = (r_state == c_IDLE) && (start || init_req);
  assign w_accept_cmd = (r_state == c_IDLE) && start && !init_req;

  always_comb begin
    w_last_idx = c_BIT_W'(7);
    case (r_state)
      c_INIT:     w_last_idx = c_BIT_W'(INIT_CLKS - 1);
      c_SEND:     w_last_idx = c_BIT_W'(47);
      c_READ_EXT: w_last_idx = c_BIT_W'(31);
      default:    w_last_idx = c_BIT_W'(7);
    endcase
  end

  // State register
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) r_state <= c_IDLE;
    else             r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (init_req)   w_state_nxt = c_INIT;
        else if (start) w_state_nxt = c_PRE;
      end
      c_INIT:     if (w_bit_end) w_state_nxt = c_DONE;
      c_PRE:      if (w_bit_end) w_state_nxt = c_SEND;
      c_SEND:     if (w_bit_end) w_state_nxt = c_WAIT;
      c_WAIT: begin
        if (w_bit_end) begin
          if (!r_shift[7])               w_state_nxt = r_resp_len ? c_READ_EXT : c_POST;
          else if (r_byte == c_NCR_LAST) w_state_nxt = c_POST;
        end
      end
      c_READ_EXT: if (w_bit_end) w_state_nxt = c_POST;
      c_POST:     if (w_bit_end) w_state_nxt = c_DONE;
      c_DONE:     w_state_nxt = c_IDLE;
      default:    w_state_nxt = c_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy    = w_active;
    done    = (r_state == c_DONE);
    SD_MOSI = (r_state == c_SEND) ? r_frame[47] : 1'b1;
  end

  assign SD_SCK  = r_sck;
  assign timeout = r_timeout;
  assign r1      = r_r1;
  assign r_ext   = r_ext_q;

  // Clock divider, counters and response capture
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      r_div      <= '0;
      r_sck      <= 1'b0;
      r_bit      <= '0;
      r_byte     <= '0;
      r_frame    <= '1;
      r_shift    <= 8'hFF;
      r_resp_len <= 1'b0;
      r_timeout  <= 1'b0;
      r_r1       <= 8'hFF;
      r_ext_q    <= '0;
    end else begin
      if (!w_active || w_half_end) r_div <= '0;
      else                         r_div <= r_div + 1'b1;

      if (!w_active)       r_sck <= 1'b0;
      else if (w_half_end) r_sck <= ~r_sck;

      // Bit counter holds at its terminal value; in WAIT it restarts per byte.
      if (w_state_nxt != r_state) begin
        r_bit <= '0;
      end else if (w_fall) begin
        if (w_bit_last && r_state == c_WAIT) r_bit <= '0;
        else if (!w_bit_last)                r_bit <= r_bit + 1'b1;
      end

      if (w_state_nxt != r_state)
        r_byte <= '0;
      else if (r_state == c_WAIT && w_bit_end && r_byte != c_NCR_LAST)
        r_byte <= r_byte + 1'b1;

      if (w_accept_any) begin
        r_ext_q   <= '0;
        r_timeout <= 1'b0;
      end
      if (w_accept_cmd) begin
        r_frame    <= {2'b01, cmd_index, cmd_arg, w_crc, 1'b1};
        r_resp_len <= resp_len;
      end

      if (r_state == c_SEND && w_fall)
        r_frame <= {r_frame[46:0], 1'b1};

      if (r_state == c_WAIT && w_rise)
        r_shift <= {r_shift[6:0], SD_MISO};

      // r_shift already holds all 8 bits of the byte when its last bit ends.
      if (r_state == c_WAIT && w_bit_end) begin
        if (!r_shift[7]) begin
          r_r1 <= r_shift;
        end else if (r_byte == c_NCR_LAST) begin
          r_r1      <= 8'hFF;
          r_timeout <= 1'b1;
        end
      end

      if (r_state == c_READ_EXT && w_rise)
        r_ext_q <= {r_ext_q[30:0], SD_MISO};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sd_cmd_sequencer                                        |
// | Description : Self-checking bench for sd_cmd_sequencer with a card model |
// |               and a behavioural transaction reference model.            |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_sd_cmd_sequencer;

  localparam int CLK_DIV   = 2;
  localparam int NCR_MAX   = 8;
  localparam int INIT_CLKS = 80;
  localparam int SCK_PERIOD = 2 * CLK_DIV * 10;

`ifdef SD_CRC7_EN
  localparam logic [6:0] c_CRC_CMD0 = 7'h00;
  localparam logic [6:0] c_CRC_CMD8 = 7'h00;
`else
  localparam logic [6:0] c_CRC_CMD0 = 7'h4A;
  localparam logic [6:0] c_CRC_CMD8 = 7'h43;
`endif

  logic        CLK100MHZ = 1'b0;
  logic        CPU_RESETN = 1'b0;
  logic        start = 1'b0;
  logic        init_req = 1'b0;
  logic [5:0]  cmd_index = '0;
  logic [31:0] cmd_arg = '0;
  logic [6:0]  cmd_crc = '0;
  logic        resp_len = 1'b0;
  logic        busy, done, timeout;
  logic [7:0]  r1;
  logic [31:0] r_ext;
  logic        SD_SCK, SD_MOSI;
  logic        SD_MISO = 1'b1;

  int   n_checks = 0;
  int   n_fail = 0;
  int   rise_cnt = 0;
  int   done_cnt = 0;
  int   rise_base = 0;
  time  t_prev = 0;
  time  t_last = 0;
  bit   mosi_log[$];
  logic [7:0] resp_q[$];

  always #5 CLK100MHZ = ~CLK100MHZ;

  sd_cmd_sequencer #(
    .CLK_DIV  (CLK_DIV),
    .NCR_MAX  (NCR_MAX),
    .INIT_CLKS(INIT_CLKS)
  ) u_dut (
    .CLK100MHZ (CLK100MHZ),
    .CPU_RESETN(CPU_RESETN),
    .start     (start),
    .init_req  (init_req),
    .cmd_index (cmd_index),
    .cmd_arg   (cmd_arg),
    .cmd_crc   (cmd_crc),
    .resp_len  (resp_len),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .r1        (r1),
    .r_ext     (r_ext),
    .SD_SCK    (SD_SCK),
    .SD_MOSI   (SD_MOSI),
    .SD_MISO   (SD_MISO)
  );

  function automatic logic [7:0] resp_byte(input int j);
    if (j < resp_q.size()) return resp_q[j];
    return 8'hFF;
  endfunction

  // Card answers after the 8 preamble + 48 frame clocks; anything unscripted is 1.
  function automatic logic card_bit(input int k);
    logic [7:0] b;
    int         j;
    if (k < 56) return 1'b1;
    j = k - 56;
    b = resp_byte(j / 8);
    return b[7 - (j % 8)];
  endfunction

  // CRC7 as remainder of msg * x^7 divided by x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_ref(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  always @(posedge SD_SCK) begin
    mosi_log.push_back(SD_MOSI);
    rise_cnt++;
    t_prev = t_last;
    t_last = $time;
  end

  always @(posedge CLK100MHZ) if (done === 1'b1) done_cnt++;

  always @(negedge SD_SCK) SD_MISO = card_bit(rise_cnt - rise_base);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                       input logic rl, output logic [47:0] frame, output logic [7:0] m_r1,
                       output logic m_to, output logic [31:0] m_ext, output int m_rises);
    logic [6:0] c;
    logic [7:0] b;
    int         polled;
`ifdef SD_CRC7_EN
    c = crc7_ref({2'b01, idx, arg});
`else
    c = crc;
`endif
    frame  = {2'b01, idx, arg, c, 1'b1};
    m_r1   = 8'hFF;
    m_to   = 1'b1;
    m_ext  = '0;
    polled = NCR_MAX;
    for (int j = 0; j < NCR_MAX; j++) begin
      b = resp_byte(j);
      if (!b[7]) begin
        m_r1   = b;
        m_to   = 1'b0;
        polled = j + 1;
        if (rl) for (int k = 1; k <= 4; k++) m_ext = {m_ext[23:0], resp_byte(j + k)};
        break;
      end
    end
    m_rises = 8 + 48 + 8 * polled + ((rl && !m_to) ? 32 : 0) + 8;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLK100MHZ);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Count 0 bits on MOSI outside [lo, hi) of the current transaction.
  function automatic int zeros_outside(input int lo, input int hi);
    int z = 0;
    for (int i = 0; i < rise_cnt - rise_base; i++)
      if ((i < lo || i >= hi) && !mosi_log[rise_base + i]) z++;
    return z;
  endfunction

  task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [6:0] crc, input logic rl, output logic [47:0] obs_frame);
    logic [47:0] e_frame;
    logic [7:0]  e_r1;
    logic        e_to;
    logic [31:0] e_ext;
    int          e_rises;
    int          d0;
    bit          ok;
    model(idx, arg, crc, rl, e_frame, e_r1, e_to, e_ext, e_rises);
    rise_base = rise_cnt;
    d0        = done_cnt;
    obs_frame = '0;
    @(negedge CLK100MHZ);
    cmd_index = idx; cmd_arg = arg; cmd_crc = crc; resp_len = rl; start = 1'b1;
    @(negedge CLK100MHZ);
    start = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(ok);
    check({tag, "_done_seen"}, 64'(ok), 64'd1);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_r1"}, 64'(r1), 64'(e_r1));
    check({tag, "_timeout"}, 64'(timeout), 64'(e_to));
    check({tag, "_r_ext"}, 64'(r_ext), 64'(e_ext));
    @(negedge CLK100MHZ);
    check({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    check({tag, "_sck_rises"}, 64'(rise_cnt - rise_base), 64'(e_rises));
    if (rise_cnt - rise_base >= 56)
      for (int i = 0; i < 48; i++) obs_frame = {obs_frame[46:0], mosi_log[rise_base + 8 + i]};
    check({tag, "_frame"}, 64'(obs_frame), 64'(e_frame));
    check({tag, "_mosi_idle_ones"}, 64'(zeros_outside(8, 56)), 64'd0);
  endtask

  task automatic run_init(input string tag, input bit with_start, input bit start_mid);
    int d0;
    bit ok;
    rise_base = rise_cnt;
    d0        = done_cnt;
    @(negedge CLK100MHZ);
    cmd_index = 6'd17; cmd_arg = 32'h0; cmd_crc = 7'h00;
    init_req = 1'b1; start = with_start;
    @(negedge CLK100MHZ);
    init_req = 1'b0; start = 1'b0;
    if (start_mid) begin
      repeat (100) @(negedge CLK100MHZ);
      start = 1'b1;
      @(negedge CLK100MHZ);
      start = 1'b0;
    end
    wait_done(ok);
    check({tag, "_done_seen"}, 64'(ok), 64'd1);
    repeat (30) @(negedge CLK100MHZ);
    check({tag, "_sck_rises"}, 64'(rise_cnt - rise_base), 64'(INIT_CLKS));
    check({tag, "_mosi_ones"}, 64'(zeros_outside(0, 0)), 64'd0);
    check({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    check({tag, "_idle_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [47:0] fr;
    int          d0;
    int          nff;
    logic [5:0]  ridx;
    logic [31:0] rarg;
    logic [6:0]  rcrc;
    logic        rrl;

    repeat (5) @(negedge CLK100MHZ);
    check("rst_sck", 64'(SD_SCK), 64'd0);
    check("rst_mosi", 64'(SD_MOSI), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_r1", 64'(r1), 64'hFF);
    check("rst_r_ext", 64'(r_ext), 64'd0);
    CPU_RESETN = 1'b1;
    repeat (2) @(negedge CLK100MHZ);

    // CMD0, card idles one byte then answers 0x01
    resp_q = '{8'hFF, 8'h01};
    run_cmd("cmd0", 6'd0, 32'h0, c_CRC_CMD0, 1'b0, fr);
    check("cmd0_frame_const", 64'(fr), 64'h400000000095);
    check("cmd0_sck_period", 64'(t_last - t_prev), 64'(SCK_PERIOD));

    // CMD8 with R7 trailer
    resp_q = '{8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
    run_cmd("cmd8", 6'd8, 32'h000001AA, c_CRC_CMD8, 1'b1, fr);
    check("cmd8_frame_const", 64'(fr), 64'h48000001AA87);
    check("cmd8_r_ext_const", 64'(r_ext), 64'h000001AA);

    // CMD55 with a silent card: NCR timeout
    resp_q.delete();
    run_cmd("cmd55_to", 6'd55, 32'h0, 7'h32, 1'b0, fr);
    check("cmd55_timeout_const", 64'(timeout), 64'd1);
    check("cmd55_rises_const", 64'(rise_cnt - rise_base), 64'd128);

    // Init clocks, with a start ignored while busy, then init+start together
    resp_q.delete();
    run_init("init_busy_start", 1'b0, 1'b1);
    run_init("init_and_start", 1'b1, 1'b0);

    // Reset during SEND bit 20 (rise 8 + 21 of the transaction)
    rise_base = rise_cnt;
    d0        = done_cnt;
    @(negedge CLK100MHZ);
    cmd_index = 6'd17; cmd_arg = 32'hDEADBEEF; cmd_crc = 7'h55; resp_len = 1'b0; start = 1'b1;
    @(negedge CLK100MHZ);
    start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (rise_cnt - rise_base >= 29) break;
      @(negedge CLK100MHZ);
    end
    check("abort_reached_bit20", 64'(rise_cnt - rise_base), 64'd29);
    CPU_RESETN = 1'b0;
    @(negedge CLK100MHZ);
    check("abort_sck", 64'(SD_SCK), 64'd0);
    check("abort_mosi", 64'(SD_MOSI), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    CPU_RESETN = 1'b1;
    repeat (3) @(negedge CLK100MHZ);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);

    resp_q = '{8'h01};
    run_cmd("after_abort", 6'd0, 32'h0, c_CRC_CMD0, 1'b0, fr);
    check("after_abort_frame_const", 64'(fr), 64'h400000000095);

    // Randomised commands against the reference model
    for (int t = 0; t < 8; t++) begin
      ridx = 6'($urandom_range(0, 63));
      rarg = $urandom;
      rcrc = 7'($urandom_range(0, 127));
      rrl  = 1'($urandom_range(0, 1));
      nff  = $urandom_range(0, 9);
      resp_q.delete();
      for (int j = 0; j < nff; j++) resp_q.push_back(8'h80 | 8'($urandom));
      resp_q.push_back(8'h7F & 8'($urandom));
      for (int j = 0; j < 4; j++) resp_q.push_back(8'($urandom));
      run_cmd($sformatf("rand%0d", t), ridx, rarg, rcrc, rrl, fr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
